// File: rtl/ps2_keymap.sv
// ps2_keymap: PS/2 set-2 scan-code stream to ASCII translator.
// Parses E0/F0 prefixes, tracks Shift/Ctrl/Caps Lock, can suppress typematic
// repeats and queues characters in a small FIFO with a valid/ready handshake.
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   in_valid, scan_code   - one raw set-2 byte per strobe
//   out_valid, out_ready  - FIFO non-empty / consumer pop request
//   out_data              - ASCII character at the FIFO head
//   shift_o, ctrl_o, caps_o - registered modifier state
//   overflow              - one-cycle pulse when a character is dropped (FIFO full)
module ps2_keymap #(
    parameter int FIFO_DEPTH   = 4,
    parameter bit REPEAT_EN    = 1'b1,
    parameter bit DROP_UNKNOWN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] scan_code,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       shift_o,
    output logic       ctrl_o,
    output logic       caps_o,
    output logic       overflow
);
    localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_t;

    // Letter lookup: {hit, lower-case ASCII}
    function automatic logic [8:0] map_letter(input logic [7:0] code);
        logic [8:0] res;
        case (code)
            8'h1C: res = {1'b1, 8'h61};  8'h32: res = {1'b1, 8'h62};
            8'h21: res = {1'b1, 8'h63};  8'h23: res = {1'b1, 8'h64};
            8'h24: res = {1'b1, 8'h65};  8'h2B: res = {1'b1, 8'h66};
            8'h34: res = {1'b1, 8'h67};  8'h33: res = {1'b1, 8'h68};
            8'h43: res = {1'b1, 8'h69};  8'h3B: res = {1'b1, 8'h6A};
            8'h42: res = {1'b1, 8'h6B};  8'h4B: res = {1'b1, 8'h6C};
            8'h3A: res = {1'b1, 8'h6D};  8'h31: res = {1'b1, 8'h6E};
            8'h44: res = {1'b1, 8'h6F};  8'h4D: res = {1'b1, 8'h70};
            8'h15: res = {1'b1, 8'h71};  8'h2D: res = {1'b1, 8'h72};
            8'h1B: res = {1'b1, 8'h73};  8'h2C: res = {1'b1, 8'h74};
            8'h3C: res = {1'b1, 8'h75};  8'h2A: res = {1'b1, 8'h76};
            8'h1D: res = {1'b1, 8'h77};  8'h22: res = {1'b1, 8'h78};
            8'h35: res = {1'b1, 8'h79};  8'h1A: res = {1'b1, 8'h7A};
            default: res = 9'h000;
        endcase
        return res;
    endfunction

    // Non-letter lookup: {hit, ASCII}; shifted variant chosen by shift
    function automatic logic [8:0] map_other(input logic [7:0] code, input logic shift);
        logic [7:0] u;
        logic [7:0] s;
        logic       hit;
        hit = 1'b1;
        case (code)
            8'h16: begin u = 8'h31; s = 8'h21; end
            8'h1E: begin u = 8'h32; s = 8'h40; end
            8'h26: begin u = 8'h33; s = 8'h23; end
            8'h25: begin u = 8'h34; s = 8'h24; end
            8'h2E: begin u = 8'h35; s = 8'h25; end
            8'h36: begin u = 8'h36; s = 8'h5E; end
            8'h3D: begin u = 8'h37; s = 8'h26; end
            8'h3E: begin u = 8'h38; s = 8'h2A; end
            8'h46: begin u = 8'h39; s = 8'h28; end
            8'h45: begin u = 8'h30; s = 8'h29; end
            8'h0E: begin u = 8'h60; s = 8'h7E; end
            8'h4E: begin u = 8'h2D; s = 8'h5F; end
            8'h55: begin u = 8'h3D; s = 8'h2B; end
            8'h54: begin u = 8'h5B; s = 8'h7B; end
            8'h5B: begin u = 8'h5D; s = 8'h7D; end
            8'h5D: begin u = 8'h5C; s = 8'h7C; end
            8'h4C: begin u = 8'h3B; s = 8'h3A; end
            8'h52: begin u = 8'h27; s = 8'h22; end
            8'h41: begin u = 8'h2C; s = 8'h3C; end
            8'h49: begin u = 8'h2E; s = 8'h3E; end
            8'h4A: begin u = 8'h2F; s = 8'h3F; end
            8'h29: begin u = 8'h20; s = 8'h20; end
            8'h5A: begin u = 8'h0D; s = 8'h0D; end
            8'h66: begin u = 8'h08; s = 8'h08; end
            8'h0D: begin u = 8'h09; s = 8'h09; end
            8'h76: begin u = 8'h1B; s = 8'h1B; end
            default: begin u = 8'h00; s = 8'h00; hit = 1'b0; end
        endcase
        return {hit, (shift ? s : u)};
    endfunction

    state_t      state_r, state_nxt_s;
    logic        byte_vld_r;
    logic [7:0]  byte_r;
    logic        make_s, brk_s, ext_s;
    logic [8:0]  key_s;
    logic        lshift_r, rshift_r, lctrl_r, rctrl_r, caps_r, caps_held_r;
    logic        lshift_nxt_s, rshift_nxt_s, lctrl_nxt_s, rctrl_nxt_s, caps_nxt_s, caps_held_nxt_s;
    logic        is_lshift_s, is_rshift_s, is_lctrl_s, is_rctrl_s, is_caps_s, is_mod_s;
    logic [8:0]  last_key_r;
    logic        last_vld_r;
    logic        rpt_hit_s, rpt_drop_s;
    logic [8:0]  letter_s, other_s;
    logic        chr_vld_s;
    logic [7:0]  chr_s;
    logic [7:0]  mem_r [FIFO_DEPTH];
    logic [AW:0] wr_ptr_r, rd_ptr_r, count_s;
    logic        full_s, empty_s, pop_s, push_s, drop_s;

    // Input capture stage: the byte is interpreted one cycle after it is sampled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_vld_r <= 1'b0;
            byte_r     <= 8'h00;
        end else begin
            byte_vld_r <= in_valid;
            byte_r     <= scan_code;
        end
    end

    // Parser state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Parser next state and make/break classification of the captured byte
    always_comb begin
        state_nxt_s = state_r;
        make_s      = 1'b0;
        brk_s       = 1'b0;
        ext_s       = 1'b0;
        if (byte_vld_r) begin
            case (state_r)
                ST_IDLE: begin
                    case (byte_r)
                        8'hE0:                             state_nxt_s = ST_EXT;
                        8'hF0:                             state_nxt_s = ST_BRK;
                        8'hAA, 8'hFA, 8'hEE, 8'h00, 8'hFF: state_nxt_s = ST_IDLE;
                        default:                           make_s      = 1'b1;
                    endcase
                end
                ST_EXT: begin
                    if (byte_r == 8'hF0) begin
                        state_nxt_s = ST_EXT_BRK;
                    end else begin
                        make_s      = 1'b1;
                        ext_s       = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    brk_s       = 1'b1;
                    state_nxt_s = ST_IDLE;
                end
                ST_EXT_BRK: begin
                    brk_s       = 1'b1;
                    ext_s       = 1'b1;
                    state_nxt_s = ST_IDLE;
                end
                default: state_nxt_s = ST_IDLE;
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    assign key_s       = {ext_s, byte_r};
    assign is_lshift_s = (key_s == 9'h012);
    assign is_rshift_s = (key_s == 9'h059);
    assign is_lctrl_s  = (key_s == 9'h014);
    assign is_rctrl_s  = (key_s == 9'h114);
    assign is_caps_s   = (key_s == 9'h058);
    assign is_mod_s    = is_lshift_s | is_rshift_s | is_lctrl_s | is_rctrl_s | is_caps_s;

    // Held-key tracking; Caps toggles only on the make that starts a press
    assign lshift_nxt_s    = (make_s & is_lshift_s) | (lshift_r & ~(brk_s & is_lshift_s));
    assign rshift_nxt_s    = (make_s & is_rshift_s) | (rshift_r & ~(brk_s & is_rshift_s));
    assign lctrl_nxt_s     = (make_s & is_lctrl_s)  | (lctrl_r  & ~(brk_s & is_lctrl_s));
    assign rctrl_nxt_s     = (make_s & is_rctrl_s)  | (rctrl_r  & ~(brk_s & is_rctrl_s));
    assign caps_held_nxt_s = (make_s & is_caps_s)   | (caps_held_r & ~(brk_s & is_caps_s));
    assign caps_nxt_s      = caps_r ^ (make_s & is_caps_s & ~caps_held_r);

    // Modifier registers and their registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lshift_r    <= 1'b0;
            rshift_r    <= 1'b0;
            lctrl_r     <= 1'b0;
            rctrl_r     <= 1'b0;
            caps_r      <= 1'b0;
            caps_held_r <= 1'b0;
            shift_o     <= 1'b0;
            ctrl_o      <= 1'b0;
            caps_o      <= 1'b0;
        end else begin
            lshift_r    <= lshift_nxt_s;
            rshift_r    <= rshift_nxt_s;
            lctrl_r     <= lctrl_nxt_s;
            rctrl_r     <= rctrl_nxt_s;
            caps_r      <= caps_nxt_s;
            caps_held_r <= caps_held_nxt_s;
            shift_o     <= lshift_nxt_s | rshift_nxt_s;
            ctrl_o      <= lctrl_nxt_s | rctrl_nxt_s;
            caps_o      <= caps_nxt_s;
        end
    end

    assign rpt_hit_s  = last_vld_r && (last_key_r == key_s);
    assign rpt_drop_s = (REPEAT_EN == 1'b0) && rpt_hit_s;

    // Last-made-key register; cleared by the break of that same key
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_key_r <= 9'h000;
            last_vld_r <= 1'b0;
        end else if (make_s) begin
            last_key_r <= key_s;
            last_vld_r <= 1'b1;
        end else if (brk_s && rpt_hit_s) begin
            last_vld_r <= 1'b0;
        end else begin
            last_vld_r <= last_vld_r;
        end
    end

    assign letter_s = map_letter(byte_r);
    assign other_s  = map_other(byte_r, lshift_r | rshift_r);

    // Character generation from the make code and pre-byte modifier state
    always_comb begin
        chr_vld_s = 1'b0;
        chr_s     = 8'h00;
        if (make_s && !is_mod_s && !rpt_drop_s) begin
            if (ext_s) begin
                if (byte_r == 8'h5A) begin
                    chr_vld_s = 1'b1;
                    chr_s     = 8'h0D;
                end else begin
                    chr_vld_s = 1'b0;
                end
            end else if (letter_s[8]) begin
                chr_vld_s = 1'b1;
                if (lctrl_r | rctrl_r) begin
                    chr_s = letter_s[7:0] - 8'h60;
                end else if ((lshift_r | rshift_r) ^ caps_r) begin
                    chr_s = letter_s[7:0] - 8'h20;
                end else begin
                    chr_s = letter_s[7:0];
                end
            end else if (lctrl_r | rctrl_r) begin
                chr_vld_s = 1'b0;
            end else if (other_s[8]) begin
                chr_vld_s = 1'b1;
                chr_s     = other_s[7:0];
            end else if (!DROP_UNKNOWN) begin
                chr_vld_s = 1'b1;
                chr_s     = 8'hFF;
            end else begin
                chr_vld_s = 1'b0;
            end
        end else begin
            chr_vld_s = 1'b0;
        end
    end

    // Extra pointer bit separates full from empty
    assign count_s = wr_ptr_r - rd_ptr_r;
    assign empty_s = (wr_ptr_r == rd_ptr_r);
    assign full_s  = (count_s == DEPTH_C);
    assign pop_s   = !empty_s && out_ready;
    assign push_s  = chr_vld_s && (!full_s || pop_s);
    assign drop_s  = chr_vld_s && full_s && !pop_s;

    // Output FIFO storage, pointers and overflow pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= chr_s;
                wr_ptr_r                <= wr_ptr_r + 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            overflow <= drop_s;
        end
    end

    assign out_valid = !empty_s;
    assign out_data  = mem_r[rd_ptr_r[AW-1:0]];

endmodule

// File: tb/tb_ps2_keymap.sv
// Bench for ps2_keymap: two instances (repeats on / drop unknown, and
// repeats off / emit FF for unknown) share one stimulus stream. A key-set
// model built from lookup strings predicts the queued characters and
// modifier state every cycle; scenario tasks also check fixed outputs.
module tb_ps2_keymap;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] scan_code = 8'h00;
    logic       out_ready = 1'b1;
    logic       ov [2];
    logic [7:0] od [2];
    logic       sh [2];
    logic       ct [2];
    logic       cp [2];
    logic       ovf [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ps2_keymap #(.FIFO_DEPTH(DEPTH), .REPEAT_EN(1'b1), .DROP_UNKNOWN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .scan_code(scan_code),
        .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
        .shift_o(sh[0]), .ctrl_o(ct[0]), .caps_o(cp[0]), .overflow(ovf[0]));

    ps2_keymap #(.FIFO_DEPTH(DEPTH), .REPEAT_EN(1'b0), .DROP_UNKNOWN(1'b0)) dut_nr (
        .clk(clk), .rst(rst), .in_valid(in_valid), .scan_code(scan_code),
        .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
        .shift_o(sh[1]), .ctrl_o(ct[1]), .caps_o(cp[1]), .overflow(ovf[1]));

    // ---------------- reference tables ----------------
    int         kind  [256];   // 0 unmapped, 1 letter, 2 other
    logic [7:0] lo_ch [256];
    logic [7:0] up_ch [256];

    initial begin
        string      letters, plain, shifted;
        logic [7:0] lcode [26];
        logic [7:0] pcode [22];
        letters = "abcdefghijklmnopqrstuvwxyz";
        plain   = "1234567890`-=[]|;',./ ";
        shifted = "!@#$%^&*()~_+{}|:'<>? ";
        lcode = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
                  8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
                  8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
        pcode = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45,
                  8'h0E, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C, 8'h52, 8'h41, 8'h49,
                  8'h4A, 8'h29};
        for (int i = 0; i < 256; i++) begin
            kind[i] = 0; lo_ch[i] = 8'h00; up_ch[i] = 8'h00;
        end
        for (int i = 0; i < 26; i++) begin
            kind[lcode[i]]  = 1;
            lo_ch[lcode[i]] = letters.getc(i);
            up_ch[lcode[i]] = letters.getc(i) - 8'd32;
        end
        for (int i = 0; i < 22; i++) begin
            kind[pcode[i]]  = 2;
            lo_ch[pcode[i]] = plain.getc(i);
            up_ch[pcode[i]] = shifted.getc(i);
        end
        lo_ch[8'h5D] = 8'h5C;
        up_ch[8'h52] = 8'h22;
        kind[8'h5A] = 2; lo_ch[8'h5A] = 8'h0D; up_ch[8'h5A] = 8'h0D;
        kind[8'h66] = 2; lo_ch[8'h66] = 8'h08; up_ch[8'h66] = 8'h08;
        kind[8'h0D] = 2; lo_ch[8'h0D] = 8'h09; up_ch[8'h0D] = 8'h09;
        kind[8'h76] = 2; lo_ch[8'h76] = 8'h1B; up_ch[8'h76] = 8'h1B;
    end

    // ---------------- behavioural model ----------------
    logic [7:0] mq [2][$];
    bit         m_held [2][512];
    bit         m_ext [2], m_brk [2], m_caps [2], m_lv [2], m_ovf [2];
    int         m_last [2];
    logic       pv = 1'b0;
    logic [7:0] pb = 8'h00;

    task automatic model_edge(input int i);
        bit         has, pop, full, supp, s, c_held, is_mod;
        logic [7:0] chr;
        int         key;
        if (rst) begin
            mq[i].delete();
            m_ext[i] = 0; m_brk[i] = 0; m_caps[i] = 0; m_lv[i] = 0; m_ovf[i] = 0;
            for (int k = 0; k < 512; k++) m_held[i][k] = 0;
            return;
        end
        has = 0; chr = 8'h00;
        full = (mq[i].size() == DEPTH);
        pop  = (mq[i].size() != 0) && out_ready;
        if (pv) begin
            if (m_brk[i]) begin
                key = (m_ext[i] ? 256 : 0) + int'(pb);
                m_held[i][key] = 0;
                if (m_lv[i] && m_last[i] == key) m_lv[i] = 0;
                m_ext[i] = 0; m_brk[i] = 0;
            end else if (pb == 8'hF0) begin
                m_brk[i] = 1;
            end else if (!m_ext[i] && pb == 8'hE0) begin
                m_ext[i] = 1;
            end else if (!m_ext[i] && (pb inside {8'hAA, 8'hFA, 8'hEE, 8'h00, 8'hFF})) begin
                m_ext[i] = 0;
            end else begin
                key    = (m_ext[i] ? 256 : 0) + int'(pb);
                s      = m_held[i][9'h012] | m_held[i][9'h059];
                c_held = m_held[i][9'h014] | m_held[i][9'h114];
                supp   = (i == 1) && m_lv[i] && (m_last[i] == key);
                m_last[i] = key; m_lv[i] = 1;
                is_mod = (key == 'h12) || (key == 'h59) || (key == 'h14) || (key == 'h114) || (key == 'h58);
                if (!is_mod && !supp) begin
                    if (m_ext[i]) begin
                        if (pb == 8'h5A) begin has = 1; chr = 8'h0D; end
                    end else if (kind[pb] == 1) begin
                        has = 1;
                        chr = c_held ? (lo_ch[pb] - 8'h60) : ((s ^ m_caps[i]) ? up_ch[pb] : lo_ch[pb]);
                    end else if (!c_held) begin
                        if (kind[pb] == 2) begin has = 1; chr = s ? up_ch[pb] : lo_ch[pb]; end
                        else if (i == 1) begin has = 1; chr = 8'hFF; end
                    end
                end
                if (key == 'h58 && !m_held[i][key]) m_caps[i] = !m_caps[i];
                m_held[i][key] = 1;
                m_ext[i] = 0;
            end
        end
        if (pop) void'(mq[i].pop_front());
        m_ovf[i] = 0;
        if (has) begin
            if (!full || pop) mq[i].push_back(chr);
            else m_ovf[i] = 1;
        end
    endtask

    // Model advance: process the byte captured at the previous edge
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) model_edge(i);
        pv = rst ? 1'b0 : in_valid;
        pb = scan_code;
    end

    // Popped-character log and overflow pulse counter
    logic [63:0] got_vec [2];
    int          got_n [2];
    int          ovf_cnt [2];
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                if (ov[i] && out_ready) begin
                    got_vec[i] = {got_vec[i][55:0], od[i]};
                    got_n[i]++;
                end
                if (ovf[i]) ovf_cnt[i]++;
            end
        end
    end

    // Cycle monitor: every output against the model
    logic [7:0] mon_d;
    logic       mon_v, mon_s, mon_c;
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                mon_v = (mq[i].size() != 0);
                mon_d = mon_v ? mq[i][0] : 8'h00;
                mon_s = m_held[i][9'h012] | m_held[i][9'h059];
                mon_c = m_held[i][9'h014] | m_held[i][9'h114];
                n_checks++;
                if (ov[i] !== mon_v || (mon_v && od[i] !== mon_d) || ovf[i] !== m_ovf[i] ||
                    sh[i] !== mon_s || ct[i] !== mon_c || cp[i] !== m_caps[i]) begin
                    n_fail++;
                    $display("FAIL monitor[%0d] t=%0t: v/d/ovf/sh/ct/cp got %b/%h/%b/%b/%b/%b required %b/%h/%b/%b/%b/%b",
                             i, $time, ov[i], od[i], ovf[i], sh[i], ct[i], cp[i],
                             mon_v, mon_d, m_ovf[i], mon_s, mon_c, m_caps[i]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic v, input logic [7:0] b);
        in_valid  = v;
        scan_code = b;
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 8'h00);
    endtask

    task automatic send(input logic [63:0] bytes, input int n);
        for (int j = 0; j < n; j++) drive(1'b1, bytes[8*(n-1-j) +: 8]);
    endtask

    task automatic clear_log();
        for (int i = 0; i < 2; i++) begin
            got_vec[i] = 64'h0; got_n[i] = 0; ovf_cnt[i] = 0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (ov[i] !== 1'b0) begin n_fail++; $display("FAIL reset_valid[%0d]: got %b required 0", i, ov[i]); end
            n_checks++;
            if (od[i] !== 8'h00) begin n_fail++; $display("FAIL reset_data[%0d]: got %h required 00", i, od[i]); end
            n_checks++;
            if ({sh[i], ct[i], cp[i], ovf[i]} !== 4'b0000) begin
                n_fail++; $display("FAIL reset_mods[%0d]: got %b required 0000", i, {sh[i], ct[i], cp[i], ovf[i]});
            end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        clear_log();
        drive(1'b1, 8'h1C);
        n_checks++;
        if (ov[0] !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b required 0", ov[0]); end
        @(negedge clk);
        n_checks++;
        if (ov[0] !== 1'b1 || od[0] !== 8'h61) begin
            n_fail++; $display("FAIL basic_latency: got valid %b data %h required 1 61", ov[0], od[0]);
        end
        send(64'hF0_1C, 2);
        idle(3);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (got_n[i] !== 1 || got_vec[i] !== 64'h61) begin
                n_fail++; $display("FAIL basic_out[%0d]: got %0d chars %h required 1 chars 61", i, got_n[i], got_vec[i]);
            end
        end
    endtask

    task automatic test_shift();
        clear_log();
        drive(1'b1, 8'h12); idle(1);
        n_checks++;
        if (sh[0] !== 1'b1) begin n_fail++; $display("FAIL shift_held: got %b required 1", sh[0]); end
        send(64'h1E_F0_1E, 3);
        send(64'hF0_12, 2); idle(1);
        n_checks++;
        if (sh[0] !== 1'b0) begin n_fail++; $display("FAIL shift_released: got %b required 0", sh[0]); end
        drive(1'b1, 8'h1E); idle(3);
        n_checks++;
        if (got_n[0] !== 2 || got_vec[0] !== 64'h4032) begin
            n_fail++; $display("FAIL shift_out: got %0d chars %h required 2 chars 4032", got_n[0], got_vec[0]);
        end
    endtask

    task automatic test_caps();
        clear_log();
        send(64'h58_58_F0_58_1C_12_1C, 7);
        send(64'hF0_12, 2); idle(3);
        n_checks++;
        if (cp[0] !== 1'b1) begin n_fail++; $display("FAIL caps_on: got %b required 1", cp[0]); end
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (got_n[i] !== 2 || got_vec[i] !== 64'h4161) begin
                n_fail++; $display("FAIL caps_out[%0d]: got %0d chars %h required 2 chars 4161", i, got_n[i], got_vec[i]);
            end
        end
        send(64'h58_F0_58, 3); idle(2);
        n_checks++;
        if (cp[1] !== 1'b0) begin n_fail++; $display("FAIL caps_off: got %b required 0", cp[1]); end
    endtask

    task automatic test_ctrl();
        clear_log();
        send(64'h14_21_E0_14_F0_14_1C, 7);
        send(64'hE0_5A_E0_75_E0_F0_75, 7);
        send(64'hE0_F0_14, 3); idle(3);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (got_n[i] !== 3 || got_vec[i] !== 64'h03010D) begin
                n_fail++; $display("FAIL ctrl_out[%0d]: got %0d chars %h required 3 chars 03010d", i, got_n[i], got_vec[i]);
            end
        end
        n_checks++;
        if (ct[0] !== 1'b0) begin n_fail++; $display("FAIL ctrl_released: got %b required 0", ct[0]); end
    endtask

    task automatic test_unknown();
        clear_log();
        send(64'h05_F0_05_29_66, 5); idle(3);
        n_checks++;
        if (got_n[0] !== 2 || got_vec[0] !== 64'h2008) begin
            n_fail++; $display("FAIL unknown_drop: got %0d chars %h required 2 chars 2008", got_n[0], got_vec[0]);
        end
        n_checks++;
        if (got_n[1] !== 3 || got_vec[1] !== 64'hFF2008) begin
            n_fail++; $display("FAIL unknown_ff: got %0d chars %h required 3 chars ff2008", got_n[1], got_vec[1]);
        end
    endtask

    task automatic test_repeat();
        clear_log();
        send(64'h24_24_24_F0_24_24_F0_24, 8); idle(3);
        n_checks++;
        if (got_n[0] !== 4 || got_vec[0] !== 64'h65656565) begin
            n_fail++; $display("FAIL repeat_on: got %0d chars %h required 4 chars 65656565", got_n[0], got_vec[0]);
        end
        n_checks++;
        if (got_n[1] !== 2 || got_vec[1] !== 64'h6565) begin
            n_fail++; $display("FAIL repeat_off: got %0d chars %h required 2 chars 6565", got_n[1], got_vec[1]);
        end
    endtask

    task automatic test_overflow();
        clear_log();
        out_ready = 1'b0;
        send(64'h1C_32_21_23_24, 5); idle(2);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (ovf_cnt[i] !== 1) begin n_fail++; $display("FAIL overflow_pulse[%0d]: got %0d pulses required 1", i, ovf_cnt[i]); end
        end
        drive(1'b1, 8'h2B);
        out_ready = 1'b1;   // pop coincides with the push of 'f'
        idle(8);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (ovf_cnt[i] !== 1 || got_n[i] !== 5 || got_vec[i] !== 64'h6162636466) begin
                n_fail++; $display("FAIL full_push_pop[%0d]: got %0d pulses %0d chars %h required 1 pulses 5 chars 6162636466",
                                   i, ovf_cnt[i], got_n[i], got_vec[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive(1'b1, 8'h1C); idle(1);
        drive(1'b1, 8'hF0); idle(1);
        rst = 1'b1;
        #1;
        n_checks++;
        if (ov[0] !== 1'b0 || ov[1] !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_flush: got valid %b%b required 00", ov[0], ov[1]);
        end
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        clear_log();
        drive(1'b1, 8'h1C); idle(3);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (got_n[i] !== 1 || got_vec[i] !== 64'h61) begin
                n_fail++; $display("FAIL reset_mid_out[%0d]: got %0d chars %h required 1 chars 61", i, got_n[i], got_vec[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] pool [24];
        logic [7:0] b;
        pool = '{8'h1C, 8'h32, 8'h24, 8'h2B, 8'h16, 8'h1E, 8'h4E, 8'h5D, 8'h29, 8'h5A, 8'h12, 8'h59,
                 8'h14, 8'h58, 8'hF0, 8'hF0, 8'hE0, 8'hAA, 8'h05, 8'h75, 8'h66, 8'h52, 8'h4A, 8'h0E};
        for (int n = 0; n < 800; n++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) b = 8'($urandom);
            else b = pool[$urandom_range(0, 23)];
            drive(($urandom_range(0, 3) != 0), b);
        end
        out_ready = 1'b1;
        idle(10);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_shift();
        test_caps();
        test_ctrl();
        test_unknown();
        test_repeat();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ps2_keymap.md
# ps2_keymap

PS/2 set-2 scan-code stream to ASCII translator with modifier tracking and a buffered output.
- Sits between the PS/2 receiver (one byte per `in_valid` pulse) and the character consumers (VGA text console, string buffer).
- Unlike a bare lookup, it interprets prefix and break bytes itself.
- It tracks Shift, Ctrl and Caps Lock, optionally suppresses typematic repeats, and queues characters in a small FIFO with a valid/ready handshake.

## Interface
Parameters:
- `FIFO_DEPTH`, 4 — output queue entries; power of two, 2..16.
- `REPEAT_EN`, 1 — 1: typematic repeats of a held key produce characters; 0: only the first make per press.
- `DROP_UNKNOWN`, 1 — 1: unmapped make codes produce nothing; 0: they enqueue `8'hFF`.

Ports:
- `clk`  in  1  — system clock; all state changes on the rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `in_valid`  in  1  — one-cycle strobe; `scan_code` is valid this cycle.
- `scan_code`  in  8  — raw set-2 byte from the PS/2 receiver.
- `out_valid`  out  1  — FIFO non-empty.
- `out_ready`  in  1  — consumer pops the head when `out_valid & out_ready`.
- `out_data`  out  8  — ASCII at the FIFO head.
- `shift_o`, `ctrl_o`, `caps_o`  out  1 each — current modifier state, registered.
- `overflow`  out  1  — one-cycle pulse when a character is dropped because the FIFO is full.

## Operation
Parser FSM, advanced only on `in_valid`, with states IDLE, EXT, BRK and EXT_BRK:
- IDLE:
  - `E0` → EXT.
  - `F0` → BRK.
  - `AA`, `FA`, `EE`, `00` and `FF` are ignored.
  - Any other byte is a make code; stay in IDLE.
- EXT:
  - `F0` → EXT_BRK.
  - Any other byte is an extended make → IDLE.
- BRK: any byte is a break code → IDLE.
- EXT_BRK: any byte is an extended break → IDLE.
- A prefix byte received in the wrong state (e.g. `E0` in BRK) is consumed as that state's code byte; no recovery special case.

Modifiers:
- Shift is held while either L-shift `12` or R-shift `59` is held; track the two keys separately.
- Ctrl is held while `14` or `E0 14` is held.
- Caps Lock (`58`) toggles `caps_o` on the first make only. Repeats while held do not toggle, regardless of `REPEAT_EN`; toggling resumes after the `F0 58` break.
- A modifier make or break never produces a character.

Translation of non-extended makes:
- Base map is the standard US layout: digits, letters, space `29`→`20`, and punctuation `0E 4E 55 54 5B 5D 4C 52 41 49 4A`, with shifted variants (`1`/`!` … `` ` ``/`~`).
- Additional codes: `5A`→`0D`, `66`→`08`, `0D`→`09`, `76`→`1B`.
- Letters are upper case when shift XOR caps; digits and punctuation follow Shift only.
- When Ctrl is held, a letter yields `01..1A` (a=`01`) and overrides case. Ctrl with any non-letter yields nothing.

Extended makes:
- Only `E0 5A` (keypad Enter) → `0D`.
- Other extended makes produce nothing but still update the held-key tracker.

Repeat suppression (`REPEAT_EN`=0):
- Register the last made code (including its extended flag).
- An identical make is dropped until the break of that code is received.
- A different make replaces the register.

FIFO:
- Push when a character is produced.
- If full and no pop this cycle: drop the character and pulse `overflow`.
- Simultaneous push and pop when full: both succeed, no drop.
- Pop when empty is ignored.

## Timing
- Reset values: FSM=IDLE, FIFO empty, `out_valid`=0, `out_data`=`00`, all modifiers 0, `overflow`=0, repeat register cleared.
- Reset asserted mid-sequence (e.g. after `F0`) discards the partial sequence and all queued data immediately.
- Latency: a byte sampled at edge k writes its character into the FIFO at edge k+1. When the FIFO was empty, `out_valid`=1 and `out_data` is valid after edge k+1.
- Modifier outputs update at edge k+1; a character in the same byte stream uses the modifier state from before that byte.
- Throughput: one input byte per cycle with no stall; `in_valid` on consecutive cycles must be handled.
- Pop: head advances at the edge where `out_valid & out_ready`=1; the next entry is visible the following cycle.
- Pointers wrap modulo `FIFO_DEPTH`; a full/empty ambiguity is not acceptable (use an extra count or pointer bit).

## Test plan
- Reset, then send `1C`, `F0`, `1C` → exactly one `61` output; FSM back in IDLE; `out_valid` rises the cycle after `1C`.
- Send `12`, `1E`, `F0 1E`, `F0 12`, `1E` → outputs `40` then `32`; `shift_o` is 1 exactly between `12` and `F0 12`.
- Caps: `58`, `58` (repeat), `F0 58`, `1C`, `12`, `1C` → outputs `41` then `61`; `caps_o`=1.
- Ctrl: `14`, `21` → `03`; `E0 14`, `F0 14`, `1C` → `01` (E0 Ctrl still held); `E0 5A` → `0D`; `E0 75` → nothing.
- With `REPEAT_EN`=0: `24`, `24`, `24`, `F0 24`, `24` → outputs `65`, `65`. With `REPEAT_EN`=1 the same stimulus gives four `65`.
- Hold `out_ready`=0 and send `FIFO_DEPTH`+1 letters → first `FIFO_DEPTH` kept in order and one `overflow` pulse. With the FIFO full, send one more letter while `out_ready`=1 that same cycle → no overflow and order preserved. Assert `rst` after a lone `F0`, then send `1C` → `61` emitted.
